cycle_sequencer: RTL and testbench

Run-control and step scheduler for the segment-cycle display animation. Generates single-cycle step pulses at a selectable rate and the up/down direction that drives the animation's position counter. Counts laps and optionally reverses direction after a programmable number of laps, with a dwell pause at each turnaround. Sits between the board button/switch inputs and the animation counter and display logic.

---
 rtl/cycle_sequencer.sv | 179 +++++++++++++++++
 tb/tb_cycle_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cycle_sequencer.sv
// Run-control and step scheduler for the segment-cycle display animation.
// Build option CYCLE_SEQ_ONESHOT_EN: with auto_rev = 0, stop in IDLE after LAPS laps.
module cycle_sequencer #(
  parameter int unsigned TICK_DIV      = 12_500_000,
  parameter int unsigned STEPS_PER_LAP = 8,
  parameter int unsigned LAPS          = 2,
  parameter int unsigned DWELL_STEPS   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] speed,
  input  logic       auto_rev,
  output logic       step,
  output logic       up,
  output logic       active,
  output logic [3:0] lap_cnt
);

  localparam int unsigned TW = $clog2(TICK_DIV + 1);
  localparam int unsigned PW = $clog2(STEPS_PER_LAP);
  localparam int unsigned DW = $clog2(DWELL_STEPS + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    spd_q, spd_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          turn_q, turn_d;
  logic          step_d, up_d, active_d;
  logic [3:0]    lap_d;
`ifdef CYCLE_SEQ_ONESHOT_EN
  logic          done_q, done_d;
`endif

  logic [TW-1:0] period_c;
  logic          term_c;
  logic [3:0]    lap_inc_c;

  // Step period follows the latched speed, never the live input.
  assign period_c  = TW'(TICK_DIV >> spd_q);
  assign term_c    = (tick_q == (period_c - TW'(1)));
  assign lap_inc_c = (lap_cnt == 4'hF) ? 4'hF : (lap_cnt + 4'd1);

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    spd_d    = spd_q;
    pos_d    = pos_q;
    dwell_d  = dwell_q;
    lap_d    = lap_cnt;
    up_d     = up;
    step_d   = 1'b0;
    turn_d   = 1'b0;
    active_d = 1'b0;
`ifdef CYCLE_SEQ_ONESHOT_EN
    done_d   = done_q;
`endif

    // Direction flips the cycle after the turnaround step so it never shares a step cycle.
    if (turn_q) begin
      up_d = ~up;
    end

    if (state_q != IDLE) begin
      if (term_c) begin
        tick_d = '0;
        spd_d  = speed;
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          tick_d  = '0;
          spd_d   = speed;
`ifdef CYCLE_SEQ_ONESHOT_EN
          if (done_q) begin
            lap_d  = '0;
            done_d = 1'b0;
          end
`endif
        end
      end

      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (term_c) begin
          step_d = 1'b1;
          if (pos_q == PW'(STEPS_PER_LAP - 1)) begin
            pos_d = '0;
            if (auto_rev && (lap_inc_c >= 4'(LAPS))) begin
              lap_d   = '0;
              turn_d  = 1'b1;
              dwell_d = '0;
              state_d = HOLD;
            end else begin
              lap_d = lap_inc_c;
`ifdef CYCLE_SEQ_ONESHOT_EN
              if (!auto_rev && (lap_inc_c >= 4'(LAPS))) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
`endif
            end
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end
      end

      HOLD: begin
        if (stop) begin
          state_d = IDLE;
        end else if (term_c) begin
          if (dwell_q == DW'(DWELL_STEPS - 1)) begin
            dwell_d = '0;
            state_d = RUN;
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == IDLE) begin
      tick_d = '0;
    end
    active_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      spd_q   <= '0;
      pos_q   <= '0;
      dwell_q <= '0;
      turn_q  <= 1'b0;
      step    <= 1'b0;
      up      <= 1'b1;
      active  <= 1'b0;
      lap_cnt <= '0;
`ifdef CYCLE_SEQ_ONESHOT_EN
      done_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      spd_q   <= spd_d;
      pos_q   <= pos_d;
      dwell_q <= dwell_d;
      turn_q  <= turn_d;
      step    <= step_d;
      up      <= up_d;
      active  <= active_d;
      lap_cnt <= lap_d;
`ifdef CYCLE_SEQ_ONESHOT_EN
      done_q  <= done_d;
`endif
    end
  end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Scoreboard bench for cycle_sequencer: stimulus queues expected steps, a monitor checks them.
module tb_cycle_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic [1:0] speed;
  logic       auto_rev;
  logic       step;
  logic       up;
  logic       active;
  logic [3:0] lap_cnt;

  typedef struct {
    int cyc;
    int up;
    int lap;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   nstep = 0;
  int   s;
  int   t;

  cycle_sequencer #(
    .TICK_DIV      (8),
    .STEPS_PER_LAP (8),
    .LAPS          (2),
    .DWELL_STEPS   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .speed    (speed),
    .auto_rev (auto_rev),
    .step     (step),
    .up       (up),
    .active   (active),
    .lap_cnt  (lap_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int u, input int l);
    exp_t e;
    e.cyc = c;
    e.up  = u;
    e.lap = l;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: every step pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && step === 1'b1) begin
      exp_t e;
      nstep++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL step%0d: unexpected step at cyc %0d", nstep, cyc);
      end else begin
        e = sb.pop_front();
        if (cyc != e.cyc || int'(up) != e.up || int'(lap_cnt) != e.lap) begin
          bad++;
          $display("FAIL step%0d: got cyc=%0d up=%0d lap=%0d want cyc=%0d up=%0d lap=%0d",
                   nstep, cyc, up, lap_cnt, e.cyc, e.up, e.lap);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; speed = 2'd0; auto_rev = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_step", step, 0);
    chk("rst_up", up, 1);
    chk("rst_active", active, 0);
    chk("rst_lap", lap_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic run at speed 0, then stop on a step-due cycle after 9 steps.
    s = cyc + 1; start = 1'b1;
    for (int k = 1; k <= 9; k++) push(s + 8 * k, 1, (k >= 8) ? 1 : 0);
    @(negedge clk); start = 1'b0;
    chk("run_active", active, 1);
    chk("run_up", up, 1);
    chk("run_nostep", step, 0);
    wait_cyc(s + 64);
    chk("lap_after_64", lap_cnt, 1);
    wait_cyc(s + 79); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("stop_active", active, 0);
    chk("stop_nostep", step, 0);
    chk("stop_lap", lap_cnt, 1);

    // Resume from lap 1 / position 1; speed change mid-period.
    repeat (6) @(negedge clk);
    s = cyc + 1; start = 1'b1;
    push(s + 8, 1, 1);
    push(s + 16, 1, 1);
    for (int k = 24; k <= 27; k++) push(s + k, 1, 1);
    @(negedge clk); start = 1'b0;
    wait_cyc(s + 20); speed = 2'd3;
    wait_cyc(s + 27); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("stop2_active", active, 0);
    chk("stop2_lap", lap_cnt, 1);

    // Resume at position 7: the first step wraps the lap; then start+stop together.
    repeat (3) @(negedge clk);
    s = cyc + 1; start = 1'b1;
    push(s + 1, 1, 2);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("wrap_lap", lap_cnt, 2);
    start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    chk("ss_active", active, 0);
    chk("ss_lap", lap_cnt, 2);

    // Auto-reverse at speed 0 with dwell.
    rst = 1'b1; @(negedge clk); rst = 1'b0; speed = 2'd0; auto_rev = 1'b1;
    @(negedge clk);
    s = cyc + 1; start = 1'b1;
    for (int k = 1; k <= 16; k++) push(s + 8 * k, 1, (k == 16) ? 0 : ((k >= 8) ? 1 : 0));
    t = s + 128;
    push(t + 40, 0, 0);
    push(t + 48, 0, 0);
    @(negedge clk); start = 1'b0;
    wait_cyc(t);
    chk("turn_lap", lap_cnt, 0);
    chk("turn_up_on_step", up, 1);
    @(negedge clk);
    chk("hold_up", up, 0);
    chk("hold_active", active, 1);
    wait_cyc(t + 20);
    chk("hold_active_mid", active, 1);
    chk("hold_nostep", step, 0);
    wait_cyc(t + 50); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("rev_stop_active", active, 0);
    chk("rev_stop_up", up, 0);

    // Fast auto-reverse, asynchronous reset during HOLD.
    rst = 1'b1; @(negedge clk); rst = 1'b0; speed = 2'd3; auto_rev = 1'b1;
    @(negedge clk);
    s = cyc + 1; start = 1'b1;
    for (int k = 1; k <= 16; k++) push(s + k, 1, (k == 16) ? 0 : ((k >= 8) ? 1 : 0));
    @(negedge clk); start = 1'b0;
    wait_cyc(s + 18);
    chk("fhold_up", up, 0);
    chk("fhold_active", active, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_step", step, 0);
    chk("arst_up", up, 1);
    chk("arst_active", active, 0);
    chk("arst_lap", lap_cnt, 0);
    @(negedge clk); rst = 1'b0; auto_rev = 1'b0;
    @(negedge clk);

`ifdef CYCLE_SEQ_ONESHOT_EN
    // One-shot: 16 steps then IDLE; restart clears the lap count.
    s = cyc + 1; start = 1'b1;
    for (int k = 1; k <= 16; k++) push(s + k, 1, k / 8);
    @(negedge clk); start = 1'b0;
    wait_cyc(s + 18);
    chk("os_active", active, 0);
    chk("os_lap", lap_cnt, 2);
    s = cyc + 1; start = 1'b1;
    for (int k = 1; k <= 16; k++) push(s + k, 1, k / 8);
    @(negedge clk); start = 1'b0;
    chk("os_restart_lap", lap_cnt, 0);
    chk("os_restart_active", active, 1);
    wait_cyc(s + 20);
    chk("os2_active", active, 0);
    chk("os2_lap", lap_cnt, 2);
`else
    // No auto-reverse: stepping continues and the lap count saturates at 15.
    s = cyc + 1; start = 1'b1;
    for (int k = 1; k <= 130; k++) push(s + k, 1, (k / 8 > 15) ? 15 : k / 8);
    @(negedge clk); start = 1'b0;
    wait_cyc(s + 20);
    chk("cont_active", active, 1);
    wait_cyc(s + 130); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("sat_active", active, 0);
    chk("sat_lap", lap_cnt, 15);
`endif

    repeat (5) @(negedge clk);
    chk("missing_steps", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
